// File: rtl/mux_scan_nb_if.sv
// mux_scan_nb_if
//   Bundles the data/control signals of the display scan multiplexer.
//   Parameters:
//     WIDTH    - bits per channel
//     CHANNELS - number of channels (>= 2)
//   Signals:
//     mode     - 0 = auto scan, 1 = manual hold
//     sel_in   - channel requested in manual mode
//     data_in  - packed channel data, channel k at [k*WIDTH +: WIDTH]
//     O        - registered selected data
//     sel_out  - registered index of the channel on O
//     an_n     - registered active-low one-hot channel enable
//     tick     - registered one-cycle prescaler wrap pulse
//   Modports: master (data source / observer side), slave (multiplexer side).
interface mux_scan_nb_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
);
  localparam int SELW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

  logic                      mode;
  logic [SELW-1:0]           sel_in;
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [WIDTH-1:0]          O;
  logic [SELW-1:0]           sel_out;
  logic [CHANNELS-1:0]       an_n;
  logic                      tick;

  modport master (
    output mode, sel_in, data_in,
    input  O, sel_out, an_n, tick
  );

  modport slave (
    input  mode, sel_in, data_in,
    output O, sel_out, an_n, tick
  );
endinterface

// File: rtl/mux_scan_nb.sv
// mux_scan_nb
//   Registered N-channel multiplexer for time-multiplexed seven-segment
//   scanning. A free-running prescaler advances a channel index every
//   2^DIV_BITS clocks (auto mode), or the index follows sel_in (manual mode).
//   The selected channel data, its index and an active-low one-hot enable
//   are registered out.
//   Ports:
//     clk   - system clock, rising edge
//     rst_n - asynchronous active-low reset
//     bus   - mux_scan_nb_if.slave (mode, sel_in, data_in, O, sel_out, an_n, tick)
//   Optional build macro:
//     MUX_SCAN_BLANK_EN - when defined, an_n is blanked (all ones) for one
//                         clock whenever the displayed channel changes.
module mux_scan_nb #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DIV_BITS = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_scan_nb_if.slave  bus
);
  localparam int SELW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
  localparam logic [SELW-1:0] IDX_LAST = SELW'(CHANNELS - 1);

  logic [DIV_BITS-1:0] cnt_q, cnt_d;
  logic [SELW-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]    o_q, o_d;
  logic [SELW-1:0]     sel_out_q, sel_out_d;
  logic [CHANNELS-1:0] an_n_q, an_n_d;
  logic                tick_q, tick_d;
  logic                wrap;

  // Unpack the channel bus once so the selection loop stays readable.
  logic [WIDTH-1:0] ch [CHANNELS];
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      assign ch[gi] = bus.data_in[gi*WIDTH +: WIDTH];
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q + DIV_BITS'(1);
    wrap  = (cnt_q == '1);

    // Manual requests beyond the last channel are ignored; the index holds.
    idx_d = idx_q;
    if (bus.mode) begin
      if (int'(bus.sel_in) < CHANNELS) idx_d = bus.sel_in;
    end else if (wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + SELW'(1);
    end

    // Output stage follows the current index, one clock behind it.
    o_d    = '0;
    an_n_d = '1;
    for (int k = 0; k < CHANNELS; k++) begin
      if (int'(idx_q) == k) begin
        o_d       = ch[k];
        an_n_d[k] = 1'b0;
      end
    end

`ifdef MUX_SCAN_BLANK_EN
    // Dead band: when the shown channel is about to change, keep all
    // anodes off for this one clock; the new one-hot follows next clock.
    if (idx_q != sel_out_q) an_n_d = '1;
`else
    // Anodes switch directly from the old channel to the new one.
`endif

    sel_out_d = idx_q;
    tick_d    = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      o_q       <= '0;
      sel_out_q <= '0;
      an_n_q    <= '1;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      o_q       <= o_d;
      sel_out_q <= sel_out_d;
      an_n_q    <= an_n_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.O       = o_q;
  assign bus.sel_out = sel_out_q;
  assign bus.an_n    = an_n_q;
  assign bus.tick    = tick_q;
endmodule

// File: doc/mux_scan_nb.md
# mux_scan_nb

Parametrised, registered N-channel multiplexer for time-multiplexed display scanning. It is the clocked successor of the 4-bit 2-to-1 selector. A prescaler walks a channel index through CHANNELS inputs of WIDTH bits each, or holds a manually selected channel. It drives the selected data plus an active-low one-hot channel enable. The block sits between the board's hex/segment data sources and the seven-segment decoder and anode pins.

## Interface
- WIDTH, 4: bits per channel.
- CHANNELS, 4: number of input channels, minimum 2.
- DIV_BITS, 17: prescaler width; the index advances every 2^DIV_BITS clocks.
- SELW, derived: $clog2(CHANNELS), minimum 1; not overridable.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = auto scan; 1 = manual hold.
- sel_in  input  SELW  channel requested in manual mode.
- data_in  input  CHANNELS*WIDTH  packed channel data; channel k = data_in[k*WIDTH +: WIDTH].
- O  output  WIDTH  registered selected data.
- sel_out  output  SELW  registered index of the channel shown on O.
- an_n  output  CHANNELS  registered active-low one-hot enable; bit k low means channel k is shown.
- tick  output  1  registered one-cycle pulse on prescaler wrap.

## Operation
- Prescaler cnt (DIV_BITS): increments every clk and wraps from all-ones to 0. It runs in both modes and is never cleared except by reset.
- Channel index idx (SELW), next value:
  - In auto mode (mode=0), on a cycle where cnt is all-ones, idx becomes idx+1, wrapping from CHANNELS-1 to 0. Unused codes are never reached.
  - In auto mode on any other cycle, idx holds.
  - In manual mode (mode=1), idx loads sel_in every cycle if sel_in < CHANNELS. Otherwise idx holds (out-of-range requests are ignored).
- Output stage, registered from the current idx:
  - O <= data_in slice[idx]
  - sel_out <= idx
  - an_n <= ~(1 << idx)
- tick <= (cnt == all-ones). It pulses in both modes.
- Mode change:
  - Manual to auto: scanning resumes from the held idx at the next prescaler wrap. No restart and no skip.
  - Auto to manual: sel_in takes effect on the same edge at which mode=1 is sampled.
- Simultaneous prescaler wrap and mode=1: the manual load wins and tick still pulses.

## Timing
- Reset (rst_n low, asynchronous assert, synchronous-to-clk deassert expected from the board):
  - cnt=0, idx=0, O=0, sel_out=0, an_n=all ones, tick=0.
- First cycle after reset release: the output registers load from idx=0. an_n becomes ...1110 and O becomes channel 0 one edge after the first clk.
- Latency: a data_in change appears on O 1 clk later. An idx change appears on O/sel_out/an_n 1 clk after idx updates.
- Manual mode: a sel_in change appears on the outputs 2 clk later (idx register, then output register).
- Auto period: each channel is shown for exactly 2^DIV_BITS clocks. The full scan takes CHANNELS*2^DIV_BITS clocks.
- Reset asserted mid-scan: all outputs return to reset values immediately, without waiting for clk.

## Configuration
- Macro MUX_SCAN_BLANK_EN:
  - Defined: on any cycle where the output stage would load an idx different from the current sel_out, an_n is forced to all ones for that one cycle. O and sel_out update normally. The new one-hot appears on the following cycle. This gives a one-clock dead band against ghosting. This applies in both auto and manual modes. Reset values are unchanged.
  - Not defined: an_n switches directly from the old one-hot to the new one with no dead cycle.

## Test plan
Use WIDTH=4, CHANNELS=4, DIV_BITS=2 and data_in=16'hD5A3 (ch0=3, ch1=A, ch2=5, ch3=D).
- Reset release in auto mode:
  - Required: tick pulses every 4 clk.
  - Required: O sequence 3,A,5,D,3 with 4 clk per value.
  - Required: an_n sequence 1110,1101,1011,0111,1110.
  - Required: sel_out sequence 0,1,2,3,0.
- Manual mode:
  - Stimulus: mode=1, sel_in=2.
  - Required: O=5, an_n=1011 two clk later, held across multiple ticks.
  - Stimulus: sel_in=3.
  - Required: O=D two clk later.
- Out-of-range request:
  - Stimulus: CHANNELS=3, manual mode, sel_in=3 while showing ch1.
  - Required: O stays A and an_n stays 101.
- Return to auto:
  - Stimulus: mode 1 to 0 while idx=2.
  - Required: the next tick advances to ch3 (O=D), then wraps to ch0.
- Mid-scan reset:
  - Stimulus: rst_n low for a half-cycle while showing ch2.
  - Required: O=0, an_n=1111, tick=0 immediately.
  - Required: the scan restarts at ch0 after release.
- With MUX_SCAN_BLANK_EN defined, repeat the first test.
  - Required: an_n=1111 for exactly one clk at each channel change.
  - Required: O timing is unchanged.
